riscv_amo_ctrl: RTL and testbench

RISCV_AMO_CTRL -- requirements
Module: riscv_amo_ctrl

---
 rtl/riscv_amo_pkg.sv | 50 +++++
 rtl/riscv_amo_alu.sv | 75 +++++++
 rtl/riscv_amo_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_riscv_amo_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_amo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_amo_pkg
//  Description : Shared definitions for the RISC-V A-extension controller:
//                FSM state type, funct5 operation codes, funct3 width codes,
//                memory size codes and a funct5 legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_amo_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RSP  = 2'd3
    } amo_state_e;

    // instr[31:27] operation encodings
    localparam logic [4:0] c_f5_add  = 5'b00000;
    localparam logic [4:0] c_f5_swap = 5'b00001;
    localparam logic [4:0] c_f5_lr   = 5'b00010;
    localparam logic [4:0] c_f5_sc   = 5'b00011;
    localparam logic [4:0] c_f5_xor  = 5'b00100;
    localparam logic [4:0] c_f5_or   = 5'b01000;
    localparam logic [4:0] c_f5_and  = 5'b01100;
    localparam logic [4:0] c_f5_min  = 5'b10000;
    localparam logic [4:0] c_f5_max  = 5'b10100;
    localparam logic [4:0] c_f5_minu = 5'b11000;
    localparam logic [4:0] c_f5_maxu = 5'b11100;

    // funct3 width encodings
    localparam logic [2:0] c_f3_w = 3'b010;
    localparam logic [2:0] c_f3_d = 3'b011;

    // memory access size encodings
    localparam logic [1:0] c_size_w = 2'b10;
    localparam logic [1:0] c_size_d = 2'b11;

    function automatic logic f5_is_legal(input logic [4:0] f5);
        case (f5)
            c_f5_add, c_f5_swap, c_f5_lr, c_f5_sc, c_f5_xor, c_f5_or,
            c_f5_and, c_f5_min, c_f5_max, c_f5_minu, c_f5_maxu:
                f5_is_legal = 1'b1;
            default:
                f5_is_legal = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_amo_alu.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_amo_alu
//  Description : Combinational AMO datapath. Produces the value written back
//                to memory from the loaded value and rs2.
//  Ports       : i_old    - value loaded from memory
//                i_rs2    - rs2 operand
//                i_funct5 - AMO operation select
//                i_is_d   - 1 = doubleword op, 0 = word op (bits [31:0])
//                o_new    - new memory value (word results zero-extended)
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_amo_alu
    import riscv_amo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_funct5,
    input  logic            i_is_d,
    output logic [XLEN-1:0] o_new
);

    logic [XLEN-1:0] w_d_res;
    logic [31:0]     w_w_res;
    logic [31:0]     w_a32;
    logic [31:0]     w_b32;

    assign w_a32 = i_old[31:0];
    assign w_b32 = i_rs2[31:0];

    // Full-width result (only selected for doubleword ops)
    always_comb begin
        w_d_res = i_rs2;
        case (i_funct5)
            c_f5_add:  w_d_res = i_old + i_rs2;
            c_f5_xor:  w_d_res = i_old ^ i_rs2;
            c_f5_and:  w_d_res = i_old & i_rs2;
            c_f5_or:   w_d_res = i_old | i_rs2;
            c_f5_min:  w_d_res = ($signed(i_old) < $signed(i_rs2)) ? i_old : i_rs2;
            c_f5_max:  w_d_res = ($signed(i_old) > $signed(i_rs2)) ? i_old : i_rs2;
            c_f5_minu: w_d_res = (i_old < i_rs2) ? i_old : i_rs2;
            c_f5_maxu: w_d_res = (i_old > i_rs2) ? i_old : i_rs2;
            default:   w_d_res = i_rs2;
        endcase
    end

    // 32-bit result: compares and wrap-around happen at word width
    always_comb begin
        w_w_res = w_b32;
        case (i_funct5)
            c_f5_add:  w_w_res = w_a32 + w_b32;
            c_f5_xor:  w_w_res = w_a32 ^ w_b32;
            c_f5_and:  w_w_res = w_a32 & w_b32;
            c_f5_or:   w_w_res = w_a32 | w_b32;
            c_f5_min:  w_w_res = ($signed(w_a32) < $signed(w_b32)) ? w_a32 : w_b32;
            c_f5_max:  w_w_res = ($signed(w_a32) > $signed(w_b32)) ? w_a32 : w_b32;
            c_f5_minu: w_w_res = (w_a32 < w_b32) ? w_a32 : w_b32;
            c_f5_maxu: w_w_res = (w_a32 > w_b32) ? w_a32 : w_b32;
            default:   w_w_res = w_b32;
        endcase
    end

    always_comb begin
        o_new = '0;
        if (i_is_d) begin
            o_new = w_d_res;
        end else begin
            o_new[31:0] = w_w_res;
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_amo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_amo_ctrl
//  Description : LR/SC/AMO sequencer. Accepts one request at a time, performs
//                a read and/or write on a simple req/ack memory port, keeps
//                the LR reservation and returns a one-cycle response.
//  Ports       : clk_i/rst_ni        - clock, async active-low reset
//                req_*               - request handshake and operands
//                mem_*               - memory access port (held until ack)
//                flush_i             - clears the LR reservation
//                rsp_valid_o/_data_o/_err_o - one-cycle result
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_amo_ctrl
    import riscv_amo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [4:0]      req_funct5_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_data_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [1:0]      mem_size_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_err_o
);

    amo_state_e      r_state;
    logic [4:0]      r_funct5;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_data;
    logic            r_rsv_valid;
    logic [XLEN-1:0] r_rsv_addr;

    logic            w_legal;
    logic            w_misal;
    logic            w_sc_hit;
    logic            w_is_d;
    logic [XLEN-1:0] w_rd_ext;
    logic [XLEN-1:0] w_alu_new;
    logic [XLEN-1:0] w_sc_wdata;

    assign req_ready_o = (r_state == S_IDLE);

    // Doubleword is only legal on a 64-bit datapath
    assign w_legal  = f5_is_legal(req_funct5_i) &&
                      ((req_funct3_i == c_f3_w) || ((req_funct3_i == c_f3_d) && (XLEN == 64)));
    assign w_misal  = (req_funct3_i == c_f3_d) ? (req_addr_i[2:0] != 3'd0)
                                               : (req_addr_i[1:0] != 2'd0);
    assign w_sc_hit = r_rsv_valid && (r_rsv_addr == req_addr_i);
    assign w_is_d   = (r_funct3 == c_f3_d);

    // Loaded value as returned to rd: word loads are sign-extended
    always_comb begin
        w_rd_ext = {XLEN{mem_rdata_i[31]}};
        w_rd_ext[31:0] = mem_rdata_i[31:0];
        if (w_is_d) begin
            w_rd_ext = mem_rdata_i;
        end
    end

    always_comb begin
        w_sc_wdata = '0;
        w_sc_wdata[31:0] = req_data_i[31:0];
        if (req_funct3_i == c_f3_d) begin
            w_sc_wdata = req_data_i;
        end
    end

    riscv_amo_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .i_old    (mem_rdata_i),
        .i_rs2    (r_data),
        .i_funct5 (r_funct5),
        .i_is_d   (w_is_d),
        .o_new    (w_alu_new)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_funct5    <= '0;
            r_funct3    <= '0;
            r_data      <= '0;
            r_rsv_valid <= 1'b0;
            r_rsv_addr  <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_size_o  <= '0;
            mem_wdata_o <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_funct5   <= req_funct5_i;
                        r_funct3   <= req_funct3_i;
                        r_data     <= req_data_i;
                        mem_addr_o <= req_addr_i;
                        mem_size_o <= req_funct3_i[1:0];
                        if (!w_legal || w_misal) begin
                            r_state     <= S_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_data_o  <= '0;
                        end else if (req_funct5_i == c_f5_sc) begin
                            if (w_sc_hit) begin
                                r_state     <= S_WR;
                                mem_req_o   <= 1'b1;
                                mem_we_o    <= 1'b1;
                                mem_wdata_o <= w_sc_wdata;
                            end else begin
                                r_state     <= S_RSP;
                                rsp_valid_o <= 1'b1;
                                rsp_err_o   <= 1'b0;
                                rsp_data_o  <= XLEN'(1);
                            end
                        end else begin
                            r_state   <= S_RD;
                            mem_req_o <= 1'b1;
                            mem_we_o  <= 1'b0;
                        end
                        // Every SC consumes the reservation, hit or miss
                        if (req_funct5_i == c_f5_sc) begin
                            r_rsv_valid <= 1'b0;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ack_i) begin
                        if (mem_err_i) begin
                            r_state     <= S_RSP;
                            mem_req_o   <= 1'b0;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_data_o  <= '0;
                            r_rsv_valid <= 1'b0;
                        end else if (r_funct5 == c_f5_lr) begin
                            r_state     <= S_RSP;
                            mem_req_o   <= 1'b0;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_data_o  <= w_rd_ext;
                            r_rsv_valid <= 1'b1;
                            r_rsv_addr  <= mem_addr_o;
                        end else begin
                            // rd value is captured now; it is presented after the write
                            r_state     <= S_WR;
                            mem_we_o    <= 1'b1;
                            mem_wdata_o <= w_alu_new;
                            rsp_data_o  <= w_rd_ext;
                        end
                    end
                end
                S_WR: begin
                    if (mem_ack_i) begin
                        r_state     <= S_RSP;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= mem_err_i;
                        if (mem_err_i) begin
                            rsp_data_o  <= '0;
                            r_rsv_valid <= 1'b0;
                        end else if (r_funct5 == c_f5_sc) begin
                            rsp_data_o <= '0;
                        end
                    end
                end
                S_RSP: begin
                    r_state     <= S_IDLE;
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // Flush has the last word over any reservation set above
            if (flush_i) begin
                r_rsv_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_amo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_amo_ctrl
//  Description : Self-checking bench for riscv_amo_ctrl (XLEN=32): directed
//                vector table, multi-cycle sequences, and random operations
//                compared against a word-addressed reference memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_amo_ctrl;

    localparam int XLEN = 32;

    localparam logic [4:0] F_ADD = 5'h00, F_SWAP = 5'h01, F_LR = 5'h02, F_SC = 5'h03,
                           F_XOR = 5'h04, F_OR = 5'h08, F_AND = 5'h0C, F_MIN = 5'h10,
                           F_MAX = 5'h14, F_MINU = 5'h18, F_MAXU = 5'h1C;
    localparam logic [2:0] W3 = 3'b010, D3 = 3'b011;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [4:0]      req_funct5_i = '0;
    logic [2:0]      req_funct3_i = '0;
    logic [XLEN-1:0] req_addr_i = '0;
    logic [XLEN-1:0] req_data_i = '0;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [1:0]      mem_size_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_err_i;
    logic            flush_i = 1'b0;
    logic            rsp_valid_o;
    logic [XLEN-1:0] rsp_data_o;
    logic            rsp_err_o;

    riscv_amo_ctrl #(.XLEN(XLEN)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_funct5_i (req_funct5_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_size_o   (mem_size_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i),
        .flush_i      (flush_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_delay = 0;
    bit inj_err = 1'b0;
    int n_acc = 0;
    int n_wr  = 0;

    logic [31:0] mem_dut [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          rsv_v = 1'b0;
    logic [31:0] rsv_a = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay extra cycles, checks that the
    // request stays stable while waiting.
    initial begin : responder
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        logic [1:0]  sz;
        bit          aborted;
        mem_ack_i   = 1'b0;
        mem_err_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            mem_err_i = 1'b0;
            if (mem_req_o && rst_ni) begin
                a = mem_addr_o; wd = mem_wdata_o; we = mem_we_o; sz = mem_size_o;
                aborted = 1'b0;
                for (int k = 0; k < ack_delay; k++) begin
                    @(posedge clk_i); #1;
                    if (!rst_ni) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("hold_req_we_size", {60'd0, mem_req_o, mem_we_o, mem_size_o}, {60'd0, 1'b1, we, sz});
                    check("hold_addr", {32'd0, mem_addr_o}, {32'd0, a});
                    check("hold_wdata", {32'd0, mem_wdata_o}, {32'd0, wd});
                end
                if (!aborted) begin
                    mem_ack_i = 1'b1;
                    mem_err_i = inj_err;
                    n_acc++;
                    if (we) begin
                        n_wr++;
                        if (!inj_err) mem_dut[a] = wd;
                    end else begin
                        mem_rdata_i = mem_dut.exists(a) ? mem_dut[a] : 32'hDEADBEEF;
                    end
                end
            end
        end
    end

    // Issue one request (called at posedge+#1 with the DUT idle); wait for the response.
    task automatic do_op(input logic [4:0] f5, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit flush_during,
                         output logic [31:0] rd, output logic err, output int lat);
        int n;
        check("ready_before_req", {63'd0, req_ready_o}, 64'd1);
        req_valid_i = 1'b1; req_funct5_i = f5; req_funct3_i = f3;
        req_addr_i = a; req_data_i = d;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_addr_i = $urandom; req_data_i = $urandom; req_funct5_i = 5'($urandom);
        if (flush_during) flush_i = 1'b1;
        n = 1;
        while (!rsp_valid_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("rsp_valid_seen", {63'd0, rsp_valid_o}, 64'd1);
        rd = rsp_data_o; err = rsp_err_o; lat = n;
        flush_i = 1'b0;
        @(posedge clk_i); #1;
        check("rsp_one_cycle", {62'd0, rsp_valid_o, req_ready_o}, 64'd1);
    endtask

    // Reference model: applies one operation to ref_mem / reservation.
    function automatic void ref_op(input logic [4:0] f5, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] d, input bit berr,
                                   output bit e_err, output logic [31:0] e_data, output int e_acc);
        bit          legal;
        bit          hit;
        logic [31:0] old;
        logic [31:0] nv;
        legal = (f3 == W3) && (f5 inside {F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
                                          F_MIN, F_MAX, F_MINU, F_MAXU});
        e_err = 1'b0; e_data = '0; e_acc = 0;
        if (!legal || a[1:0] != 2'd0) begin
            e_err = 1'b1;
            if (f5 == F_SC) rsv_v = 1'b0;
            return;
        end
        if (f5 == F_LR) begin
            e_acc = 1;
            if (berr) begin e_err = 1'b1; rsv_v = 1'b0; end
            else begin e_data = ref_mem[a]; rsv_v = 1'b1; rsv_a = a; end
        end else if (f5 == F_SC) begin
            hit = rsv_v && (rsv_a == a);
            rsv_v = 1'b0;
            if (hit) begin
                e_acc = 1;
                if (berr) e_err = 1'b1;
                else ref_mem[a] = d;
            end else begin
                e_data = 32'd1;
            end
        end else begin
            e_acc = 1;
            old = ref_mem[a];
            if (berr) begin
                e_err = 1'b1; rsv_v = 1'b0;
            end else begin
                e_acc = 2;
                case (f5)
                    F_ADD:  nv = old + d;
                    F_XOR:  nv = old ^ d;
                    F_AND:  nv = old & d;
                    F_OR:   nv = old | d;
                    F_MIN:  nv = ($signed(old) < $signed(d)) ? old : d;
                    F_MAX:  nv = ($signed(old) < $signed(d)) ? d : old;
                    F_MINU: nv = (old < d) ? old : d;
                    F_MAXU: nv = (old < d) ? d : old;
                    default: nv = d;
                endcase
                ref_mem[a] = nv;
                e_data = old;
            end
        end
    endfunction

    typedef struct {
        logic [4:0]  f5;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] init;
        bit          e_err;
        logic [31:0] e_data;
        logic [31:0] e_mem;
        int          e_acc;
        int          e_lat;
    } vec_t;

    vec_t        vt [15];
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc0;
    int          wr0;
    bit          e_err;
    logic [31:0] e_data;
    int          e_acc;
    logic [31:0] aw;
    logic [4:0]  ops [11];
    logic [4:0]  f5;
    logic [2:0]  f3;
    logic [31:0] ra;
    logic [31:0] rdat;
    logic [31:0] last_lr;

    initial begin
        vt[0]  = '{F_ADD,  W3,    32'h100, 32'h1,        32'h7FFFFFFF, 0, 32'h7FFFFFFF, 32'h80000000, 2, 3};
        vt[1]  = '{F_MINU, W3,    32'h104, 32'h2,        32'hFFFFFFFF, 0, 32'hFFFFFFFF, 32'h00000002, 2, 3};
        vt[2]  = '{F_MIN,  W3,    32'h108, 32'h2,        32'hFFFFFFFF, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 3};
        vt[3]  = '{F_SWAP, W3,    32'h102, 32'h5,        32'h11111111, 1, 32'h0,        32'h11111111, 0, 1};
        vt[4]  = '{F_ADD,  D3,    32'h100, 32'h1,        32'h22222222, 1, 32'h0,        32'h22222222, 0, 1};
        vt[5]  = '{F_XOR,  W3,    32'h10C, 32'hFF00FF00, 32'hF0F0F0F0, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 2, 3};
        vt[6]  = '{F_AND,  W3,    32'h110, 32'h0F0F0F0F, 32'h12345678, 0, 32'h12345678, 32'h02040608, 2, 3};
        vt[7]  = '{F_MAX,  W3,    32'h114, 32'h1,        32'h80000000, 0, 32'h80000000, 32'h00000001, 2, 3};
        vt[8]  = '{F_MAXU, W3,    32'h118, 32'h1,        32'h80000000, 0, 32'h80000000, 32'h80000000, 2, 3};
        vt[9]  = '{5'h05,  W3,    32'h120, 32'h1,        32'h33333333, 1, 32'h0,        32'h33333333, 0, 1};
        vt[10] = '{F_ADD,  3'b000,32'h124, 32'h1,        32'h55555555, 1, 32'h0,        32'h55555555, 0, 1};
        vt[11] = '{F_SC,   W3,    32'h11C, 32'h9,        32'h44444444, 0, 32'h1,        32'h44444444, 0, 1};
        vt[12] = '{F_OR,   W3,    32'h128, 32'h0000000F, 32'h0000F000, 0, 32'h0000F000, 32'h0000F00F, 2, 3};
        vt[13] = '{F_SWAP, W3,    32'h12C, 32'h00005555, 32'h0000AAAA, 0, 32'h0000AAAA, 32'h00005555, 2, 3};
        vt[14] = '{F_LR,   W3,    32'h131, 32'h0,        32'h66666666, 1, 32'h0,        32'h66666666, 0, 1};

        ops = '{F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU, F_MAXU};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ctrl", {58'd0, req_ready_o, mem_req_o, mem_we_o, rsp_valid_o, rsp_err_o, 1'b0},
              {58'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset_addr_wdata", {mem_addr_o, mem_wdata_o}, 64'd0);
        check("reset_rsp_data", {32'd0, rsp_data_o}, 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // ---------------- vector table ----------------
        for (int i = 0; i < 15; i++) begin
            aw = vt[i].addr & ~32'h3;
            mem_dut[aw] = vt[i].init;
            ack_delay = 0; inj_err = 1'b0;
            acc0 = n_acc;
            do_op(vt[i].f5, vt[i].f3, vt[i].addr, vt[i].data, 1'b0, rd, err, lat);
            check($sformatf("vec%0d_err", i), {63'd0, err}, {63'd0, vt[i].e_err});
            if (!vt[i].e_err) check($sformatf("vec%0d_data", i), {32'd0, rd}, {32'd0, vt[i].e_data});
            check($sformatf("vec%0d_mem", i), {32'd0, mem_dut[aw]}, {32'd0, vt[i].e_mem});
            check($sformatf("vec%0d_accesses", i), 64'(n_acc - acc0), 64'(vt[i].e_acc));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].e_lat));
        end

        // ---------------- LR / SC / SC ----------------
        mem_dut[32'h200] = 32'hCAFEF00D;
        do_op(F_LR, W3, 32'h200, 32'h0, 1'b0, rd, err, lat);
        check("lr_data", {31'd0, err, rd}, {32'd0, 32'hCAFEF00D});
        check("lr_latency", 64'(lat), 64'd2);
        acc0 = n_acc; wr0 = n_wr;
        do_op(F_SC, W3, 32'h200, 32'h5, 1'b0, rd, err, lat);
        check("sc_ok_data", {31'd0, err, rd}, 64'd0);
        check("sc_ok_latency", 64'(lat), 64'd2);
        check("sc_ok_write", {32'(n_wr - wr0), mem_dut[32'h200]}, {32'd1, 32'd5});
        acc0 = n_acc;
        do_op(F_SC, W3, 32'h200, 32'h7, 1'b0, rd, err, lat);
        check("sc_again_data", {31'd0, err, rd}, 64'd1);
        check("sc_again_noaccess", 64'(n_acc - acc0), 64'd0);

        // ---------------- LR, flush pulse, SC ----------------
        do_op(F_LR, W3, 32'h200, 32'h0, 1'b0, rd, err, lat);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        acc0 = n_acc;
        do_op(F_SC, W3, 32'h200, 32'h9, 1'b0, rd, err, lat);
        check("flush_sc_data", {31'd0, err, rd}, 64'd1);
        check("flush_sc_noaccess", 64'(n_acc - acc0), 64'd0);

        // ---------------- flush during LR wins, LR still completes ----------------
        mem_dut[32'h210] = 32'h01234567;
        do_op(F_LR, W3, 32'h210, 32'h0, 1'b1, rd, err, lat);
        check("lr_flush_data", {31'd0, err, rd}, {32'd0, 32'h01234567});
        acc0 = n_acc;
        do_op(F_SC, W3, 32'h210, 32'h9, 1'b0, rd, err, lat);
        check("lr_flush_sc_fail", {31'd0, err, rd}, 64'd1);
        check("lr_flush_sc_noaccess", 64'(n_acc - acc0), 64'd0);

        // ---------------- AMOOR.W, delayed ack with bus error ----------------
        mem_dut[32'h240] = 32'h0000000F;
        ack_delay = 4; inj_err = 1'b1;
        acc0 = n_acc; wr0 = n_wr;
        do_op(F_OR, W3, 32'h240, 32'h000000F0, 1'b0, rd, err, lat);
        ack_delay = 0; inj_err = 1'b0;
        check("berr_err", {63'd0, err}, 64'd1);
        check("berr_accesses", {32'(n_acc - acc0), 32'(n_wr - wr0)}, {32'd1, 32'd0});
        check("berr_mem", {32'd0, mem_dut[32'h240]}, {32'd0, 32'h0000000F});
        check("berr_latency", 64'(lat), 64'd6);

        // ---------------- reset mid-operation clears reservation ----------------
        mem_dut[32'h260] = 32'h1;
        mem_dut[32'h250] = 32'h2;
        do_op(F_LR, W3, 32'h260, 32'h0, 1'b0, rd, err, lat);
        ack_delay = 5;
        req_valid_i = 1'b1; req_funct5_i = F_ADD; req_funct3_i = W3;
        req_addr_i = 32'h250; req_data_i = 32'h1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check("midop_req_high", {63'd0, mem_req_o}, 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midop_async_drop", {61'd0, mem_req_o, req_ready_o, rsp_valid_o}, {61'd0, 1'b0, 1'b1, 1'b0});
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        ack_delay = 0;
        @(posedge clk_i); #1;
        acc0 = n_acc;
        do_op(F_SC, W3, 32'h260, 32'h3, 1'b0, rd, err, lat);
        check("reset_clears_rsv", {31'd0, err, rd}, 64'd1);
        check("reset_sc_noaccess", 64'(n_acc - acc0), 64'd0);
        check("midop_no_write", {32'd0, mem_dut[32'h250]}, 64'd2);

        // ---------------- random vs reference model ----------------
        rsv_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdat = $urandom;
            mem_dut[32'h300 + 4*i] = rdat;
            ref_mem[32'h300 + 4*i] = rdat;
        end
        last_lr = 32'h300;
        for (int i = 0; i < 200; i++) begin
            f5 = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 15) == 0) f5 = 5'($urandom);
            f3 = ($urandom_range(0, 11) == 0) ? D3 : W3;
            ra = 32'h300 + 4 * $urandom_range(0, 15);
            if (f5 == F_SC && $urandom_range(0, 2) != 0) ra = last_lr;
            if ($urandom_range(0, 9) == 0) ra = ra + 32'($urandom_range(1, 3));
            if (f5 == F_LR) last_lr = ra;
            case ($urandom_range(0, 3))
                0: rdat = 32'($urandom_range(0, 7));
                1: rdat = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
                2: rdat = 32'h80000000 + 32'($urandom_range(0, 3)) - 32'd2;
                default: rdat = $urandom;
            endcase
            ack_delay = $urandom_range(0, 3);
            inj_err = ($urandom_range(0, 9) == 0);
            acc0 = n_acc;
            ref_op(f5, f3, ra, rdat, inj_err, e_err, e_data, e_acc);
            do_op(f5, f3, ra, rdat, 1'b0, rd, err, lat);
            aw = ra & ~32'h3;
            check($sformatf("rnd%0d_err f5=%h a=%h", i, f5, ra), {63'd0, err}, {63'd0, e_err});
            if (!e_err) check($sformatf("rnd%0d_data f5=%h a=%h", i, f5, ra), {32'd0, rd}, {32'd0, e_data});
            check($sformatf("rnd%0d_mem a=%h", i, aw), {32'd0, mem_dut[aw]}, {32'd0, ref_mem[aw]});
            check($sformatf("rnd%0d_accesses", i), 64'(n_acc - acc0), 64'(e_acc));
        end
        ack_delay = 0; inj_err = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
